// File: rtl/rt_pkg.sv
// rt_pkg: shared FSM states and timing constants for reaction_timer
package rt_pkg;
  typedef enum logic [2:0] {
    S_Idle,
    S_AnnWait,
    S_Delay,
    S_Lit,
    S_Report,
    S_Release
  } state_t;
  localparam logic [9:0]  MAX_REACTION_MS = 10'd999;
  localparam logic [10:0] SLOW_MS         = 11'd1000;
  localparam logic [15:0] MIN_DELAY_MS    = 16'd1000;
  localparam logic [15:0] LFSR_SEED       = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS       = 16'hB400;
endpackage

// File: rtl/rt_lfsr.sv
// rt_lfsr: free-running 16-bit Galois LFSR (taps 16,14,13,11) used for the random pre-LED delay
module rt_lfsr
  import rt_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  output logic [15:0] Value
);
  // shift right, folding the output bit back through the tap mask
  always_ff @(posedge Clk)
    Value <= Rst ? LFSR_SEED : ({1'b0, Value[15:1]} ^ (Value[0] ? LFSR_TAPS : 16'h0000));
endmodule

// File: rtl/reaction_timer.sv
// reaction_timer: LED reaction-time game FSM with LCD handshake; RT_RANDOM_DELAY_EN selects an LFSR-based random pre-LED delay
module reaction_timer
  import rt_pkg::*;
#(
  parameter int CLK_PER_MS     = 50000,
  parameter int FIXED_DELAY_MS = 2000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       React,
  input  logic       LCDAck,
  output logic [7:0] LED,
  output logic       Cheat,
  output logic       Slow,
  output logic       Wait,
  output logic [9:0] ReactionTime,
  output logic       LCDUpdate
);
  localparam int PW = $clog2(CLK_PER_MS + 1);
  state_t state, state_n;
  logic start_q, react_q, start_p, react_p, tick;
  logic [PW-1:0] presc;
  logic [15:0] dly, dly_n, delay_ms;
  logic [9:0] ms, ms_n, rt_n;
  logic upd_n, cheat_n, slow_n, wait_n;
`ifdef RT_RANDOM_DELAY_EN
  logic [15:0] lfsr;
  rt_lfsr u_lfsr (
    .Clk(Clk),
    .Rst(Rst),
    .Value(lfsr)
  );
  assign delay_ms = MIN_DELAY_MS + {6'd0, lfsr[9:0]};
`else
  assign delay_ms = 16'(FIXED_DELAY_MS);
`endif
  assign start_p = Start & ~start_q;
  assign react_p = React & ~react_q;
  assign tick    = presc == PW'(CLK_PER_MS - 1);
  assign LED     = (state == S_Lit) ? 8'hFF : 8'h00;
  // button history for press (rising edge) detection
  always_ff @(posedge Clk) begin
    start_q <= Rst ? 1'b0 : Start;
    react_q <= Rst ? 1'b0 : React;
  end
  // ms prescaler restarts on every state change so each state sees whole ticks
  always_ff @(posedge Clk)
    presc <= (Rst || tick || state_n != state) ? '0 : presc + 1'b1;
  // next-state, counters and registered display outputs
  always_comb begin
    state_n = state;
    cheat_n = Cheat;
    slow_n  = Slow;
    wait_n  = Wait;
    rt_n    = ReactionTime;
    dly_n   = dly;
    ms_n    = ms;
    case (state)
      S_Idle:
        if (start_p) begin
          state_n = S_AnnWait;
          wait_n  = 1'b1;
          cheat_n = 1'b0;
          slow_n  = 1'b0;
        end
      S_AnnWait:
        if (LCDUpdate && LCDAck) begin
          state_n = S_Delay;
          dly_n   = delay_ms;
        end
      S_Delay:
        if (react_p) begin
          state_n = S_Report;
          cheat_n = 1'b1;
          wait_n  = 1'b0;
        end else if (tick) begin
          if (dly <= 16'd1) begin
            state_n = S_Lit;
            ms_n    = '0;
          end else
            dly_n = dly - 16'd1;
        end
      S_Lit:
        if (react_p) begin
          state_n = S_Report;
          rt_n    = ms;
          cheat_n = 1'b0;
          slow_n  = 1'b0;
          wait_n  = 1'b0;
        end else if (tick) begin
          if (11'(ms) + 11'd1 == SLOW_MS) begin
            state_n = S_Report;
            rt_n    = MAX_REACTION_MS;
            slow_n  = 1'b1;
            cheat_n = 1'b0;
            wait_n  = 1'b0;
          end else
            ms_n = ms + 10'd1;
        end
      S_Report:
        if (LCDUpdate && LCDAck) state_n = S_Release;
      S_Release:
        if (!LCDAck) state_n = S_Idle;
      default: state_n = S_Idle;
    endcase
    upd_n = (state_n == S_AnnWait || state_n == S_Report) && !LCDAck;
  end
  // state and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= S_Idle;
      LCDUpdate    <= 1'b0;
      Cheat        <= 1'b0;
      Slow         <= 1'b0;
      Wait         <= 1'b0;
      ReactionTime <= '0;
      dly          <= '0;
      ms           <= '0;
    end else begin
      state        <= state_n;
      LCDUpdate    <= upd_n;
      Cheat        <= cheat_n;
      Slow         <= slow_n;
      Wait         <= wait_n;
      ReactionTime <= rt_n;
      dly          <= dly_n;
      ms           <= ms_n;
    end
  end
endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter CLK_PER_MS, default 50000, Clk cycles per 1 ms tick.
REQ-002 Parameter FIXED_DELAY_MS, default 2000, pre-LED delay when random delay is compiled out.
REQ-003 Clk  in  1  system clock; all logic on its rising edge.
REQ-004 Rst  in  1  synchronous, active-high reset.
REQ-005 Start  in  1  debounced, synchronous start button level.
REQ-006 React  in  1  debounced, synchronous reaction button level.
REQ-007 LED  out  8  stimulus LEDs: all on = go, all off otherwise.
REQ-008 Cheat  out  1  display-message flag "No Cheating!".
REQ-009 Slow  out  1  display-message flag "Too Slow!".
REQ-010 Wait  out  1  display-message flag "Wait for LEDs...".
REQ-011 ReactionTime  out  10  measured time in ms, 0..999.
REQ-012 LCDUpdate  out  1  display update request.
REQ-013 LCDAck  in  1  display acknowledge, high while the display has taken the request.

Function
REQ-014 States SHALL be S_Idle, S_AnnWait, S_Delay, S_Lit, S_Report, S_Release.
REQ-015 Start and React SHALL be edge-detected internally: a press is a 0->1 transition between consecutive Clk cycles.
REQ-016 A 1 ms tick SHALL pulse for one cycle every CLK_PER_MS cycles; its prescaler SHALL clear on every state entry.
REQ-017 S_Idle: on a Start press -> S_AnnWait; React presses are ignored.
REQ-018 S_AnnWait: Wait=1, Cheat=Slow=0, LCDUpdate=1; on LCDAck=1 -> drop LCDUpdate, load the delay counter, -> S_Delay.
REQ-019 S_Delay: count ticks down; a React press -> Cheat=1, Wait=0 -> S_Report; counter reaching 0 -> LED=8'hFF, clear the ms counter -> S_Lit.
REQ-020 S_Lit: increment the ms counter per tick; a React press -> ReactionTime=counter, flags all 0 -> S_Report.
REQ-021 S_Lit: on the tick where the counter would become 1000 -> Slow=1, ReactionTime=999 -> S_Report.
REQ-022 S_Report: LED=0, LCDUpdate=1, flags and ReactionTime stable; on LCDAck=1 -> LCDUpdate=0 -> S_Release.
REQ-023 S_Release: hold until LCDAck=0, then -> S_Idle.
REQ-024 LCDUpdate SHALL never re-assert while LCDAck=1.
REQ-025 At most one of Cheat/Slow/Wait SHALL be high at any time; flags SHALL hold until the next update.
REQ-026 A React press and the delay expiry in the same cycle SHALL count as Cheat.
REQ-027 A React press and the 1000 ms tick in the same cycle SHALL record the reaction, not Slow.
REQ-028 Start presses outside S_Idle SHALL be ignored.

Reset
REQ-029 Rst SHALL force S_Idle, LED=0, Cheat=Slow=Wait=0, ReactionTime=0, LCDUpdate=0, and clear all counters and edge-detect registers.
REQ-030 Rst during any handshake SHALL drop LCDUpdate on the next edge; the LFSR seed SHALL be 16'hACE1.

Configuration
REQ-031 With RT_RANDOM_DELAY_EN defined, the delay SHALL be 1000 + LFSR[9:0] ms (1000..2023).
REQ-032 With RT_RANDOM_DELAY_EN defined, the LFSR SHALL advance every Clk cycle, so its value depends on when Start is pressed.
REQ-033 Without RT_RANDOM_DELAY_EN, the delay SHALL be FIXED_DELAY_MS and no LFSR logic SHALL be instantiated.

Structure
REQ-034 Package rt_pkg SHALL hold the state enum, MAX_REACTION_MS=999, SLOW_MS=1000, MIN_DELAY_MS=1000 and LFSR_SEED.
REQ-035 Sub-module rt_lfsr SHALL implement a 16-bit Galois LFSR with taps 16,14,13,11, present only under RT_RANDOM_DELAY_EN.

Verification (CLK_PER_MS=4, FIXED_DELAY_MS=10, macro off)
REQ-036 Start press, LCDAck held 2 cycles -> Wait=1 with LCDUpdate=1 -> LCDUpdate drops, then after 40 cycles LED=8'hFF.
REQ-037 React press 25 ms after LED on -> Report state with ReactionTime=25, flags 0, LED=0.
REQ-038 React press 5 ms into the delay -> Cheat=1, LED never lit, LCDUpdate=1 until LCDAck.
REQ-039 No React for 1000 ms -> Slow=1, ReactionTime=999; a React press on the same tick instead gives ReactionTime=999 with Slow=0.
REQ-040 Rst asserted while LCDUpdate=1 awaits LCDAck -> next cycle all outputs 0, state S_Idle; a later Start press works normally.
REQ-041 With the macro on -> each delay falls in 1000..2023 ms, and Start presses at different cycles give different delays.
